// File: rtl/scratch_ram_ctrl.sv
// Single-port scratchpad RAM with a hardware clear sequencer, a registered read port and an auto-increment pointer.
// Read data arrives one clock after the strobe; accesses made while a clear runs are refused and flagged on drop.
module scratch_ram_ctrl #(
  parameter int                ADDR_W  = 6,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ptr_mode,
  input  logic              ptr_load,
  input  logic              clr_req,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] ptr,
  output logic              drop
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                vld_q, vld_d;
  logic                drop_q, drop_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  logic [ADDR_W-1:0]   ea;
  logic                acc_req;
  logic                acc_ok;

  // A pointer load always addresses the load value, regardless of mode.
  assign ea      = (ptr_load || !ptr_mode) ? addr : ptr_q;
  assign acc_req = wr_en | rd_en;
  assign acc_ok  = acc_req & (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ptr_d     = ptr_q;
    rdata_d   = rdata_q;
    vld_d     = 1'b0;
    drop_d    = drop_q;
    mem_we    = 1'b0;
    mem_wa    = ea;
    mem_wd    = wdata;

    if (ena) begin
      case (state_q)
        ST_CLEAR: begin
          mem_we    = 1'b1;
          mem_wa    = clr_cnt_q;
          mem_wd    = CLR_VAL;
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          if (&clr_cnt_q) state_d = ST_IDLE;
          if (acc_req)    drop_d  = 1'b1;
        end
        ST_IDLE: begin
          mem_we = wr_en;
          if (rd_en) begin
            rdata_d = mem[ea];
            vld_d   = 1'b1;
          end
          if (clr_req) state_d = ST_CLEAR;
        end
        default: state_d = ST_CLEAR;
      endcase

      if (ptr_load) begin
        ptr_d = addr + ADDR_W'(acc_ok);
      end else if (ptr_mode && acc_ok) begin
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ptr_q     <= '0;
      rdata_q   <= '0;
      vld_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
      rdata_q   <= rdata_d;
      vld_q     <= vld_d;
      drop_q    <= drop_d;
    end
  end

  // Storage has no reset; the clear sequencer initialises it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign rdata       = rdata_q;
  assign rdata_valid = vld_q;
  assign busy        = (state_q == ST_CLEAR);
  assign ptr         = ptr_q;
  assign drop        = drop_q;

endmodule

// File: tb/tb_scratch_ram_ctrl.sv
// Directed bench for scratch_ram_ctrl: a behavioural reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_scratch_ram_ctrl;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       ena      = 1'b0;
  logic       wr_en    = 1'b0;
  logic       rd_en    = 1'b0;
  logic       ptr_mode = 1'b0;
  logic       ptr_load = 1'b0;
  logic       clr_req  = 1'b0;
  logic [5:0] addr     = '0;
  logic [7:0] wdata    = '0;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       busy;
  logic [5:0] ptr;
  logic       drop;

  int checks = 0;
  int errors = 0;
  int n, m;

  always #5 clk = ~clk;

  scratch_ram_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .wdata      (wdata),
    .ptr_mode   (ptr_mode),
    .ptr_load   (ptr_load),
    .clr_req    (clr_req),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .busy       (busy),
    .ptr        (ptr),
    .drop       (drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: remaining clear words, a plain array for storage, integer pointer.
  logic [7:0] mem_m [64];
  int         clr_left;
  int         ptr_m;
  int         ea_m;
  int         acc_m;
  logic       drop_m;
  logic       vld_m;
  logic [7:0] rd_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_left = 64;
      ptr_m    = 0;
      drop_m   = 1'b0;
      vld_m    = 1'b0;
      rd_m     = 8'h00;
    end else if (!ena) begin
      vld_m = 1'b0;
    end else begin
      acc_m = (wr_en || rd_en) ? 1 : 0;
      vld_m = 1'b0;
      if (clr_left != 0) begin
        mem_m[64 - clr_left] = 8'h00;
        clr_left = clr_left - 1;
        if (acc_m != 0) drop_m = 1'b1;
        if (ptr_load) ptr_m = int'(addr);
      end else begin
        ea_m = ptr_load ? int'(addr) : (ptr_mode ? ptr_m : int'(addr));
        if (rd_en) begin
          rd_m  = mem_m[ea_m];
          vld_m = 1'b1;
        end
        if (wr_en) mem_m[ea_m] = wdata;
        if (ptr_load)                   ptr_m = (int'(addr) + acc_m) % 64;
        else if (ptr_mode && acc_m != 0) ptr_m = (ptr_m + 1) % 64;
        if (clr_req) clr_left = 64;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp rdata", rdata, rd_m);
    chk("cmp rdata_valid", rdata_valid, vld_m);
    chk("cmp busy", busy, clr_left != 0);
    chk("cmp ptr", ptr, ptr_m);
    chk("cmp drop", drop, drop_m);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 300) begin
      tick();
      cnt++;
    end
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] e, input string nm);
    addr  = a;
    rd_en = 1'b1;
    tick();
    chk({nm, " data"}, rdata, e);
    chk({nm, " valid"}, rdata_valid, 1);
    rd_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " busy"}, busy, 1);
    chk({nm, " rdata"}, rdata, 0);
    chk({nm, " valid"}, rdata_valid, 0);
    chk({nm, " ptr"}, ptr, 0);
    chk({nm, " drop"}, drop, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ena = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("reset");
    tick();
    tick();
    rst_n = 1'b1;
    wait_idle(n);
    chk("initial clear length", n, 64);
    for (int a = 0; a < 64; a++) rd(6'(a), 8'h00, "post-reset read");

    // Direct write/read and read-before-write at the top address.
    addr = 6'h3F; wdata = 8'hA5; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd(6'h3F, 8'hA5, "read A5");
    addr = 6'h3F; wdata = 8'h11; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    chk("rbw old data", rdata, 8'hA5);
    wr_en = 1'b0; rd_en = 1'b0;
    rd(6'h3F, 8'h11, "rbw new data");
    tick();
    chk("valid one pulse", rdata_valid, 0);

    // Enable gating: valid is suppressed, rdata and memory hold.
    addr = 6'h3F; rd_en = 1'b1;
    tick();
    chk("ena1 valid", rdata_valid, 1);
    ena = 1'b0;
    tick();
    chk("ena0 valid dropped", rdata_valid, 0);
    chk("ena0 rdata holds", rdata, 8'h11);
    rd_en = 1'b0; wr_en = 1'b1; wdata = 8'hCC;
    tick();
    wr_en = 1'b0; ena = 1'b1;
    rd(6'h3F, 8'h11, "ena0 no write");

    // Pointer load and auto-increment with wrap.
    addr = 6'h3E; ptr_load = 1'b1;
    tick();
    chk("ptr load", ptr, 6'h3E);
    ptr_load = 1'b0; ptr_mode = 1'b1; wr_en = 1'b1; addr = 6'h00;
    wdata = 8'h01; tick(); chk("ptr inc 1", ptr, 6'h3F);
    wdata = 8'h02; tick(); chk("ptr wrap", ptr, 6'h00);
    wdata = 8'h03; tick(); chk("ptr inc 3", ptr, 6'h01);
    wr_en = 1'b0; ptr_mode = 1'b0;
    rd(6'h3E, 8'h01, "ptr wr 3E");
    rd(6'h3F, 8'h02, "ptr wr 3F");
    rd(6'h00, 8'h03, "ptr wr 00");
    addr = 6'h10; ptr_load = 1'b1; wr_en = 1'b1; wdata = 8'h77;
    tick();
    chk("ptr load with access", ptr, 6'h11);
    ptr_load = 1'b0; wr_en = 1'b0;
    rd(6'h10, 8'h77, "load write data");
    ptr_mode = 1'b1; addr = 6'h00; rd_en = 1'b1;
    tick();
    chk("ptr mode read data", rdata, 8'h00);
    chk("ptr mode read ptr", ptr, 6'h12);
    ptr_mode = 1'b0; rd_en = 1'b0;

    // Clear request with refused accesses mid-clear.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_req busy", busy, 1);
    repeat (5) tick();
    addr = 6'h3F; wdata = 8'hEE; wr_en = 1'b1;
    tick();
    chk("refused write drop", drop, 1);
    chk("refused write busy", busy, 1);
    wr_en = 1'b0; addr = 6'h05; ptr_load = 1'b1; rd_en = 1'b1;
    tick();
    chk("load during clear", ptr, 6'h05);
    chk("refused read valid", rdata_valid, 0);
    ptr_load = 1'b0; rd_en = 1'b0;
    wait_idle(n);
    chk("clear remainder", n, 57);
    for (int a = 0; a < 64; a++) rd(6'(a), 8'h00, "post-clear read");
    chk("drop sticky", drop, 1);

    // Enable dropped for 10 cycles mid-clear.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    repeat (10) begin tick(); n++; end
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ena0 busy held", busy, 1);
    end
    ena = 1'b1;
    wait_idle(m);
    chk("enabled busy total", n + m, 64);

    // Reset while a read result is valid.
    rd(6'h10, 8'h00, "pre-reset read");
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async reset read");
    tick();
    rst_n = 1'b1;
    wait_idle(n);
    chk("clear after reset", n, 64);

    // Reset at clear word 20.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("drop before reset", drop, 1);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset mid-clear");
    tick();
    rst_n = 1'b1;
    wait_idle(n);
    chk("restarted clear length", n, 64);
    rd(6'h3F, 8'h00, "final read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
